// File: rtl/mac_accum_stage_if.sv
// rtl/mac_accum_stage_if.sv - stream/handshake bundle between multiplier, accumulate stage and consumer
interface mac_accum_stage_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
);
    logic                     start;
    logic [CNT_W-1:0]         len;
    logic signed [PROD_W-1:0] in_prod;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     ovf;

    modport master (
        output start, len, in_prod, in_valid, out_ready,
        input  in_ready, out_acc, out_valid, busy, ovf
    );

    modport slave (
        input  start, len, in_prod, in_valid, out_ready,
        output in_ready, out_acc, out_valid, busy, ovf
    );
endinterface

// File: rtl/mac_accum_stage.sv
// rtl/mac_accum_stage.sv - sums LEN signed products into a wide accumulator; MAC_SAT_EN selects clamping on overflow
module mac_accum_stage #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_accum_stage_if.slave m
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;

    assign prod_ext = ACC_W'($signed(m.in_prod));
    assign sum      = acc_q + prod_ext;
    // Signed overflow: both operands share a sign that the result does not.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (m.start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (m.len != '0) begin
                        cnt_d   = m.len;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACC: begin
                if (m.in_valid) begin
                    acc_d = sum;
                    if (add_ovf) begin
                        ovf_d = 1'b1;
`ifdef MAC_SAT_EN
                        acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
`else
                        acc_d = sum;
`endif
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (m.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // All outputs come from registers or the state decode; nothing flows straight from inputs.
    assign m.in_ready  = (state_q == S_ACC);
    assign m.out_valid = (state_q == S_DONE);
    assign m.busy      = (state_q != S_IDLE);
    assign m.out_acc   = acc_q;
    assign m.ovf       = ovf_q;
endmodule
